// File: rtl/wb_regfile_pkg.sv
// Shared writeback types: widths, writeback-source encoding and the source mux.
// The control decoder imports the same encoding so both ends agree.
package wb_regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int INSTRET_W  = 64;

  typedef enum logic {
    WB_SRC_ALU  = 1'b0,
    WB_SRC_LOAD = 1'b1
  } wbSrc_t;

  function automatic logic [XLEN_DEF-1:0] selectWb(
    input wbSrc_t              src,
    input logic [XLEN_DEF-1:0] aluVal,
    input logic [XLEN_DEF-1:0] loadVal
  );
    return (src == WB_SRC_LOAD) ? loadVal : aluVal;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: two combinational read ports, one write port,
// x0 hardwired to zero and never stored.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEnable,
  input  logic [REG_ADDR_W-1:0] writeAddr,
  input  logic [XLEN-1:0]       writeData,
  input  logic [REG_ADDR_W-1:0] readAddrA,
  input  logic [REG_ADDR_W-1:0] readAddrB,
  output logic [XLEN-1:0]       readDataA,
  output logic [XLEN-1:0]       readDataB
);

  localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NREGS - 1);

  logic [XLEN-1:0] regs [1:NREGS-1];

  // NOTE: this storage is reset on purpose (registers must read zero right after
  // reset), which forces it into flops; a plain RAM would be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (writeEnable && writeAddr != '0 && writeAddr <= LAST_REG) begin
      regs[writeAddr] <= writeData;
    end
  end

  function automatic logic [XLEN-1:0] readReg(input logic [REG_ADDR_W-1:0] addr);
    if (addr == '0 || addr > LAST_REG) return '0;
    return regs[addr];
  endfunction

  // NOTE: every path through this block assigns both outputs, so no latch forms.
  always_comb begin
    readDataA = readReg(readAddrA);
    readDataB = readReg(readAddrB);
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source select, write-before-read bypass into ID, retired
// instruction counter and last retired PC.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       pc_wb,
  input  logic                  retire_i,
  input  logic                  registerWriteEnable_i,
  input  logic                  regSelect_i,
  input  logic [XLEN-1:0]       aluSrc_i,
  input  logic [XLEN-1:0]       rdData_i,
  input  logic [REG_ADDR_W-1:0] regB_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic                  wb_we_o,
  output logic [INSTRET_W-1:0]  instret_o,
  output logic [XLEN-1:0]       last_pc_o
);

  logic [XLEN-1:0]      wbData;
  logic                 wbWe;
  logic [XLEN-1:0]      rfRs1;
  logic [XLEN-1:0]      rfRs2;
  logic [INSTRET_W-1:0] instretQ;
  logic [XLEN-1:0]      lastPcQ;

  assign wbData = (wbSrc_t'(regSelect_i) == WB_SRC_LOAD) ? rdData_i : aluSrc_i;
  // A bubble or an x0 destination never qualifies as a write, so neither can bypass.
  assign wbWe   = registerWriteEnable_i && retire_i && (regB_i != '0);

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (wbWe),
    .writeAddr   (regB_i),
    .writeData   (wbData),
    .readAddrA   (rs1_addr_i),
    .readAddrB   (rs2_addr_i),
    .readDataA   (rfRs1),
    .readDataB   (rfRs2)
  );

  assign rs1_data_o = (wbWe && rs1_addr_i == regB_i) ? wbData : rfRs1;
  assign rs2_data_o = (wbWe && rs2_addr_i == regB_i) ? wbData : rfRs2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instretQ <= '0;
      lastPcQ  <= '0;
    end else if (retire_i) begin
      instretQ <= instretQ + INSTRET_W'(1);
      lastPcQ  <= pc_wb;
    end
  end

  assign wb_data_o = wbData;
  assign wb_we_o   = wbWe;
  assign instret_o = instretQ;
  assign last_pc_o = lastPcQ;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 32, data and PC width.
REQ-002 Parameter NREGS, default 32, architectural register count; address width is 5 bits.
REQ-003 Port clk, input, 1, clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, reset: asynchronous, active-low.
REQ-005 Port pc_wb, input, XLEN, PC of the instruction in WB.
REQ-006 Port retire_i, input, 1, WB slot holds a valid instruction.
REQ-007 Port registerWriteEnable_i, input, 1, WB instruction writes rd.
REQ-008 Port regSelect_i, input, 1, writeback source: 0 = ALU result, 1 = load data.
REQ-009 Port aluSrc_i, input, XLEN, ALU result from MEM/WB.
REQ-010 Port rdData_i, input, XLEN, load data from MEM/WB.
REQ-011 Port regB_i, input, 5, destination register index.
REQ-012 Port rs1_addr_i / rs2_addr_i, input, 5 each, ID-stage read addresses.
REQ-013 Port rs1_data_o / rs2_data_o, output, XLEN each, read data to ID.
REQ-014 Port wb_data_o, output, XLEN, selected writeback value (forwarding source for EX).
REQ-015 Port wb_we_o, output, 1, effective write strobe (forwarding qualifier).
REQ-016 Port instret_o, output, 64, retired-instruction count.
REQ-017 Port last_pc_o, output, XLEN, PC of most recently retired instruction.

Function
REQ-018 wb_data_o SHALL be combinational: rdData_i when regSelect_i=1, else aluSrc_i.
REQ-019 wb_we_o SHALL be registerWriteEnable_i AND retire_i AND (regB_i != 0).
REQ-020 On a rising edge with wb_we_o=1, register[regB_i] SHALL take wb_data_o; one-cycle write latency.
REQ-021 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-022 Read ports SHALL be combinational, zero-latency, and independent; identical addresses on both ports SHALL be legal.
REQ-023 Write-before-read bypass: when wb_we_o=1 and rsN_addr_i == regB_i, rsN_data_o SHALL equal wb_data_o in the same cycle.
REQ-024 registerWriteEnable_i with retire_i=0 SHALL cause no write and no counter change (bubble).
REQ-025 instret_o SHALL increment by 1 on each rising edge with retire_i=1, regardless of write enable.
REQ-026 instret_o SHALL wrap from 2^64-1 to 0 with no flag.
REQ-027 last_pc_o SHALL load pc_wb on each rising edge with retire_i=1; otherwise it holds.
REQ-028 No stall input exists; MEM/WB holds a bubble (retire_i=0) instead.

Reset
REQ-029 rst low SHALL immediately clear all registers x1..x31, instret_o, and last_pc_o to 0, independent of clk.
REQ-030 A write or retire coinciding with reset assertion SHALL be lost.
REQ-031 Combinational outputs during reset SHALL follow inputs, reading zeroed storage.
REQ-032 The first write after reset release SHALL occur on the first rising edge with rst high.

Structure
REQ-033 XLEN, register address width, and the data/regAddr/instructionAddrPath width macros SHALL come from the shared Types.v.
REQ-034 The writeback-source encoding (0 = ALU, 1 = load) SHALL be a named constant in Types.v, shared with the control decoder.
REQ-035 Register storage SHALL be one sub-module, regfile_2r1w (2 read, 1 write, x0 hardwired).
REQ-036 The bypass logic, the counter, and last_pc SHALL live in the wb_regfile top level.

Verification
REQ-037 Reset, then read all 32 registers; all SHALL return 0, with instret_o=0 and last_pc_o=0.
REQ-038 Write ALU result: retire=1, we=1, sel=0, aluSrc=0x0000_1234, rd=5; next cycle read x5 SHALL return 0x0000_1234 and instret_o SHALL be 1.
REQ-039 Load bypass: sel=1, rdData=0xDEAD_BEEF, rd=7, with rs1=7 in the same cycle; rs1_data_o SHALL be 0xDEAD_BEEF before the edge.
REQ-040 x0 and bubble: we=1 rd=0 data=0xFFFF_FFFF leaves x0=0; retire=0 we=1 rd=3 leaves x3 unchanged and instret unchanged.
REQ-041 Counter wrap: force instret to 0xFFFF_FFFF_FFFF_FFFF, retire once; instret_o SHALL be 0 and last_pc_o SHALL equal pc_wb (e.g. 0x0000_0080).
REQ-042 Reset mid-stream: write x9=0x55 while asserting rst low mid-cycle; x9, instret_o, and last_pc_o SHALL read 0 immediately.
